decode_sequencer: RTL and testbench

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer.sv | 136 +++++++++++++
 tb/tb_decode_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB, with a bounded memory wait that
// diverts to a one-cycle TRAP on timeout, and a HALT parking state.
//
// Handshake: imem_req / dmem_req are levels held for as long as the
// sequencer sits in FETCH / MEM; the cycle on which the matching *_ready is
// sampled high completes the transfer, and the request drops the next cycle.
module decode_sequencer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       dec_dmem_ren,
  input  logic       dec_dmem_wen,
  input  logic       dec_rf_wen,
  input  logic       dec_exception,
  input  logic       ext_halt,
  output logic       imem_req,
  output logic       inst_latch_en,
  output logic       dmem_req,
  output logic       rf_wen_o,
  output logic       pc_en,
  output logic       trap_en,
  output logic [1:0] trap_cause,
  output logic       halted,
  output logic [2:0] state_o
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_DEC   = 2'd1;
  localparam logic [1:0] CAUSE_IFTO  = 2'd2;
  localparam logic [1:0] CAUSE_DMTO  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      cause_q;

  // Next-state, wait counter and latched trap cause. The counter is cleared
  // on every entry into FETCH or MEM and only ever counts up to CNT_MAX, where
  // the wait either completes (ready seen) or traps, so it cannot wrap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wait_cnt == CNT_MAX) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_IFTO;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          if (dec_exception) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_DEC;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_dmem_ren || dec_dmem_wen) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state <= S_WB;
          end else if (wait_cnt == CNT_MAX) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_DMTO;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WB, S_TRAP: begin
          // ext_halt only matters at an instruction boundary.
          if (ext_halt) begin
            state <= S_HALT;
          end else begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_HALT: begin
          if (!ext_halt) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        default: begin
          // Unreachable encoding: recover through a trap with no cause.
          state   <= S_TRAP;
          cause_q <= CAUSE_NONE;
        end
      endcase
    end
  end

  // Output decode straight from the state register, so reset forces every
  // strobe and dmem_req low asynchronously.
  assign imem_req      = (state == S_FETCH);
  assign inst_latch_en = nRST && (state == S_FETCH) && imem_ready;
  assign dmem_req      = (state == S_MEM);
  assign rf_wen_o      = (state == S_WB) && dec_rf_wen;
  assign pc_en         = (state == S_WB) || (state == S_TRAP);
  assign trap_en       = (state == S_TRAP);
  assign trap_cause    = cause_q;
  assign halted        = (state == S_HALT);
  assign state_o       = state;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer (TIMEOUT_CYC = 4). Each vector is one
// clock cycle: inputs are driven just after the falling edge and outputs are
// compared 1 ns later, well away from the rising edge.
module tb_decode_sequencer;

  logic       CLK;
  logic       nRST;
  logic       imem_ready, dmem_ready;
  logic       dec_dmem_ren, dec_dmem_wen, dec_rf_wen, dec_exception, ext_halt;
  logic       imem_req, inst_latch_en, dmem_req, rf_wen_o, pc_en, trap_en;
  logic [1:0] trap_cause;
  logic       halted;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  decode_sequencer #(.TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_dmem_ren(dec_dmem_ren), .dec_dmem_wen(dec_dmem_wen),
    .dec_rf_wen(dec_rf_wen), .dec_exception(dec_exception),
    .ext_halt(ext_halt),
    .imem_req(imem_req), .inst_latch_en(inst_latch_en),
    .dmem_req(dmem_req), .rf_wen_o(rf_wen_o), .pc_en(pc_en),
    .trap_en(trap_en), .trap_cause(trap_cause), .halted(halted),
    .state_o(state_o)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]  in;   // {imem_ready, dmem_ready, ren, wen, rf_wen, exc, halt}
    logic [11:0] exp;  // {state, ireq, ile, dreq, rfw, pc, trap, cause, halted}
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] fi(input logic ir, input logic dr,
                                    input logic ren, input logic wen,
                                    input logic rfw, input logic exc,
                                    input logic hlt);
    return {ir, dr, ren, wen, rfw, exc, hlt};
  endfunction

  function automatic logic [11:0] fe(input logic [2:0] st, input logic ireq,
                                     input logic ile, input logic dreq,
                                     input logic rfw, input logic pc,
                                     input logic trp, input logic [1:0] cause,
                                     input logic hl);
    return {st, ireq, ile, dreq, rfw, pc, trp, cause, hl};
  endfunction

  function automatic logic [11:0] observed();
    return {state_o, imem_req, inst_latch_en, dmem_req, rf_wen_o, pc_en,
            trap_en, trap_cause, halted};
  endfunction

  // driver tasks
  task automatic drive(input logic [6:0] v);
    {imem_ready, dmem_ready, dec_dmem_ren, dec_dmem_wen,
     dec_rf_wen, dec_exception, ext_halt} = v;
  endtask

  task automatic check(input logic [11:0] want, input string name);
    logic [11:0] got;
    got = observed();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {st,ireq,ile,dreq,rfw,pc,trap,cause,halt}=%b want %b",
               name, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge CLK);
    drive(v.in);
    #1;
    check(v.exp, v.name);
  endtask

  task automatic step(input logic [6:0] in, input logic [11:0] want,
                      input string name);
    vec_t v;
    v.in = in; v.exp = want; v.name = name;
    apply(v);
  endtask

  task automatic add(input logic [6:0] in, input logic [11:0] want,
                     input string name);
    vec_t v;
    v.in = in; v.exp = want; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    // ADD, zero-wait fetch
    add(fi(1,0,0,0,1,0,0), fe(0,1,1,0,0,0,0,0,0), "add_fetch");
    add(fi(0,0,0,0,1,0,0), fe(1,0,0,0,0,0,0,0,0), "add_decode");
    add(fi(0,0,0,0,1,0,0), fe(2,0,0,0,0,0,0,0,0), "add_exec");
    add(fi(0,0,0,0,1,0,0), fe(4,0,0,0,1,1,0,0,0), "add_wb");
    // load, dmem_ready delayed 3 cycles (retire in 8)
    add(fi(1,0,1,0,1,0,0), fe(0,1,1,0,0,0,0,0,0), "ld_fetch");
    add(fi(0,0,1,0,1,0,0), fe(1,0,0,0,0,0,0,0,0), "ld_decode");
    add(fi(0,0,1,0,1,0,0), fe(2,0,0,0,0,0,0,0,0), "ld_exec");
    add(fi(0,0,1,0,1,0,0), fe(3,0,0,1,0,0,0,0,0), "ld_mem_w0");
    add(fi(0,0,1,0,1,0,0), fe(3,0,0,1,0,0,0,0,0), "ld_mem_w1");
    add(fi(0,0,1,0,1,0,0), fe(3,0,0,1,0,0,0,0,0), "ld_mem_w2");
    add(fi(0,1,1,0,1,0,0), fe(3,0,0,1,0,0,0,0,0), "ld_mem_rdy");
    add(fi(0,0,1,0,1,0,0), fe(4,0,0,0,1,1,0,0,0), "ld_wb");
    // store, no rd write
    add(fi(1,0,0,1,0,0,0), fe(0,1,1,0,0,0,0,0,0), "st_fetch");
    add(fi(0,0,0,1,0,0,0), fe(1,0,0,0,0,0,0,0,0), "st_decode");
    add(fi(0,0,0,1,0,0,0), fe(2,0,0,0,0,0,0,0,0), "st_exec");
    add(fi(0,1,0,1,0,0,0), fe(3,0,0,1,0,0,0,0,0), "st_mem");
    add(fi(0,0,0,1,0,0,0), fe(4,0,0,0,0,1,0,0,0), "st_wb");
    // decoder exception
    add(fi(1,0,0,0,1,0,0), fe(0,1,1,0,0,0,0,0,0), "exc_fetch");
    add(fi(0,0,0,0,1,1,0), fe(1,0,0,0,0,0,0,0,0), "exc_decode");
    add(fi(0,0,0,0,1,0,0), fe(5,0,0,0,0,1,1,1,0), "exc_trap");
    // fetch wait, ready exactly at count 4: completes normally
    add(fi(0,0,0,0,1,0,0), fe(0,1,0,0,0,0,0,1,0), "ifw_c0");
    add(fi(0,0,0,0,1,0,0), fe(0,1,0,0,0,0,0,1,0), "ifw_c1");
    add(fi(0,0,0,0,1,0,0), fe(0,1,0,0,0,0,0,1,0), "ifw_c2");
    add(fi(0,0,0,0,1,0,0), fe(0,1,0,0,0,0,0,1,0), "ifw_c3");
    add(fi(1,0,0,0,1,0,0), fe(0,1,1,0,0,0,0,1,0), "ifw_rdy_at_max");
    add(fi(0,0,0,0,1,0,0), fe(1,0,0,0,0,0,0,1,0), "ifw_decode");
    add(fi(0,0,0,0,1,0,0), fe(2,0,0,0,0,0,0,1,0), "ifw_exec");
    add(fi(0,0,0,0,1,0,1), fe(4,0,0,0,1,1,0,1,0), "ifw_wb_halt");
    add(fi(0,0,0,0,0,0,0), fe(6,0,0,0,0,0,0,1,1), "halt_leave");
    // fetch timeout: imem_ready held low
    add(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,1,0), "ifto_c0");
    add(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,1,0), "ifto_c1");
    add(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,1,0), "ifto_c2");
    add(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,1,0), "ifto_c3");
    add(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,1,0), "ifto_c4");
    add(fi(0,0,0,0,1,0,1), fe(5,0,0,0,0,1,1,2,0), "ifto_trap_halt");
    add(fi(0,0,0,0,0,0,1), fe(6,0,0,0,0,0,0,2,1), "halt_hold");
    add(fi(0,0,0,0,0,0,0), fe(6,0,0,0,0,0,0,2,1), "halt_release");
    add(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,2,0), "post_halt_fetch");

    // reset state
    drive(7'b0);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check(fe(0,1,0,0,0,0,0,0,0), "reset_state");
    drive(fi(1,0,0,0,0,0,0));
    #1;
    check(fe(0,1,0,0,0,0,0,0,0), "reset_no_latch");
    drive(7'b0);
    nRST = 1'b1;

    foreach (tbl[k]) apply(tbl[k]);

    // ext_halt raised during MEM: the load still completes, then HALT
    step(fi(1,0,1,0,1,0,0), fe(0,1,1,0,0,0,0,2,0), "hm_fetch");
    step(fi(0,0,1,0,1,0,0), fe(1,0,0,0,0,0,0,2,0), "hm_decode");
    step(fi(0,0,1,0,1,0,0), fe(2,0,0,0,0,0,0,2,0), "hm_exec");
    step(fi(0,0,1,0,1,0,1), fe(3,0,0,1,0,0,0,2,0), "hm_mem_halt");
    step(fi(0,1,1,0,1,0,1), fe(3,0,0,1,0,0,0,2,0), "hm_mem_rdy");
    step(fi(0,0,1,0,1,0,1), fe(4,0,0,0,1,1,0,2,0), "hm_wb");
    step(fi(0,0,0,0,0,0,0), fe(6,0,0,0,0,0,0,2,1), "hm_halted");

    // data-access timeout on a store
    step(fi(1,0,0,1,0,0,0), fe(0,1,1,0,0,0,0,2,0), "dto_fetch");
    step(fi(0,0,0,1,0,0,0), fe(1,0,0,0,0,0,0,2,0), "dto_decode");
    step(fi(0,0,0,1,0,0,0), fe(2,0,0,0,0,0,0,2,0), "dto_exec");
    for (int c = 0; c < 5; c++)
      step(fi(0,0,0,1,0,0,0), fe(3,0,0,1,0,0,0,2,0), $sformatf("dto_mem_c%0d", c));
    step(fi(0,0,0,0,0,0,0), fe(5,0,0,0,0,1,1,3,0), "dto_trap");

    // reset pulse mid-MEM: dmem_req drops without waiting for a clock
    step(fi(1,0,1,0,1,0,0), fe(0,1,1,0,0,0,0,3,0), "rm_fetch");
    step(fi(0,0,1,0,1,0,0), fe(1,0,0,0,0,0,0,3,0), "rm_decode");
    step(fi(0,0,1,0,1,0,0), fe(2,0,0,0,0,0,0,3,0), "rm_exec");
    step(fi(0,0,1,0,1,0,0), fe(3,0,0,1,0,0,0,3,0), "rm_mem");
    #1;
    nRST = 1'b0;
    #1;
    check(fe(0,1,0,0,0,0,0,0,0), "rm_async_reset");
    @(negedge CLK);
    drive(7'b0);
    nRST = 1'b1;
    step(fi(0,0,0,0,0,0,0), fe(0,1,0,0,0,0,0,0,0), "rm_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
